assoc_layer: RTL and testbench

Associative layer of the GAM pipeline: the consuming end of the memory layer's `assoc_learning_start` / `assoc_learning_done` handshake. On each start pulse it learns one key-class → response-class association by incrementing a saturating weight in an N_CLASS×N_CLASS matrix. It also keeps, per key class, the strongest response class for single-cycle recall. It sits directly after the memory layer and answers class-level recall queries from downstream logic.

---
 rtl/assoc_layer_pkg.sv | 30 +++
 rtl/assoc_layer_if.sv | 38 +++
 rtl/assoc_layer_controller.sv | 65 ++++++
 rtl/assoc_layer.sv | 124 ++++++++++++
 tb/tb_assoc_layer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/assoc_layer_pkg.sv
// -----------------------------------------------------------------------------
// assoc_layer_pkg
// Shared types and defaults for the associative layer of the GAM pipeline:
// default class count and weight width, the learn FSM state encoding, the
// weight and class-index types, and a class range-check helper.
// -----------------------------------------------------------------------------
package assoc_layer_pkg;

    localparam int ASSOC_N_CLASS = 16;
    localparam int ASSOC_W_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        UPD,
        DONE
    } assoc_state_T;

    typedef logic [ASSOC_W_WIDTH-1:0] assoc_weight_T;

    // Class indices travel as 32-bit signed values so that -1 can mean "none".
    typedef logic signed [31:0] assoc_class_T;

    localparam assoc_class_T ASSOC_NO_CLASS = -1;

    function automatic logic class_in_range(input assoc_class_T c, input int n);
        return (c >= 0) && (c < n);
    endfunction

endpackage

// File: rtl/assoc_layer_if.sv
// -----------------------------------------------------------------------------
// assoc_layer_if
// Learn handshake and recall query bundle of the associative layer.
//   learn : assoc_learning_start, key_c, resp_c  ->  assoc_learning_done,
//           assoc_err, busy
//   recall: query_valid, query_c  ->  recall_valid, recall_c, recall_w
// Modports: master = requester (memory layer / downstream logic),
//           slave  = assoc_layer.
// -----------------------------------------------------------------------------
interface assoc_layer_if import assoc_layer_pkg::*; #(
    parameter int W_WIDTH = ASSOC_W_WIDTH
);

    logic               assoc_learning_start;
    assoc_class_T       key_c;
    assoc_class_T       resp_c;
    logic               assoc_learning_done;
    logic               assoc_err;
    logic               busy;
    logic               query_valid;
    assoc_class_T       query_c;
    logic               recall_valid;
    assoc_class_T       recall_c;
    logic [W_WIDTH-1:0] recall_w;

    modport master (
        output assoc_learning_start, key_c, resp_c, query_valid, query_c,
        input  assoc_learning_done, assoc_err, busy,
               recall_valid, recall_c, recall_w
    );

    modport slave (
        input  assoc_learning_start, key_c, resp_c, query_valid, query_c,
        output assoc_learning_done, assoc_err, busy,
               recall_valid, recall_c, recall_w
    );

endinterface

// File: rtl/assoc_layer_controller.sv
// -----------------------------------------------------------------------------
// assoc_layer_controller
// Learn FSM of the associative layer: IDLE -> RD -> UPD -> DONE -> IDLE.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   start_i     : learn request, only honoured in IDLE
//   latch_o     : capture key/resp classes (IDLE and start)
//   rd_en_o     : range check and weight read (RD)
//   wr_en_o     : weight / best-table write (UPD)
//   done_o      : completion pulse (DONE)
//   busy_o      : FSM not in IDLE
// -----------------------------------------------------------------------------
module assoc_layer_controller import assoc_layer_pkg::*; (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    output logic latch_o,
    output logic rd_en_o,
    output logic wr_en_o,
    output logic done_o,
    output logic busy_o
);

    assoc_state_T state_q, state_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        latch_o = 1'b0;
        rd_en_o = 1'b0;
        wr_en_o = 1'b0;
        done_o  = 1'b0;
        busy_o  = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                // A start seen outside IDLE is dropped, not queued.
                if (start_i) begin
                    latch_o = 1'b1;
                    state_d = RD;
                end
            end
            RD: begin
                rd_en_o = 1'b1;
                state_d = UPD;
            end
            UPD: begin
                wr_en_o = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/assoc_layer.sv
// -----------------------------------------------------------------------------
// assoc_layer
// Associative layer of the GAM pipeline. Each learn request increments the
// saturating weight W[key][resp] and keeps, per key class, the strongest
// response class and its weight for single-cycle recall.
// Ports:
//   clk, reset : clock, synchronous active-high reset (clears all state)
//   bus        : assoc_layer_if.slave (learn handshake + recall query)
// Parameters:
//   N_CLASS    : number of classes (valid indices 0..N_CLASS-1)
//   W_WIDTH    : weight width; weights saturate at all-ones
// -----------------------------------------------------------------------------
module assoc_layer import assoc_layer_pkg::*; #(
    parameter int N_CLASS = ASSOC_N_CLASS,
    parameter int W_WIDTH = ASSOC_W_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    assoc_layer_if.slave bus
);

    localparam int IDX_W = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;

    logic latch_en, rd_en, wr_en, done;

    assoc_layer_controller u_ctrl (
        .clk     (clk),
        .reset   (reset),
        .start_i (bus.assoc_learning_start),
        .latch_o (latch_en),
        .rd_en_o (rd_en),
        .wr_en_o (wr_en),
        .done_o  (done),
        .busy_o  (bus.busy)
    );

    // ---------------- learn datapath ----------------
    assoc_class_T       key_q, resp_q;
    logic               err_q;
    logic [W_WIDTH-1:0] rd_w_q;
    logic [W_WIDTH-1:0] w_mat_q  [N_CLASS][N_CLASS];
    assoc_class_T       best_c_q [N_CLASS];
    logic [W_WIDTH-1:0] best_w_q [N_CLASS];

    logic               range_ok;
    logic [IDX_W-1:0]   key_idx, resp_idx;
    logic [W_WIDTH-1:0] w_inc;

    assign range_ok = class_in_range(key_q, N_CLASS) && class_in_range(resp_q, N_CLASS);
    assign key_idx  = key_q[IDX_W-1:0];
    assign resp_idx = resp_q[IDX_W-1:0];
    assign w_inc    = (rd_w_q == '1) ? rd_w_q : rd_w_q + W_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            key_q    <= '0;
            resp_q   <= '0;
            err_q    <= 1'b0;
            rd_w_q   <= '0;
            w_mat_q  <= '{default: '{default: '0}};
            best_c_q <= '{default: ASSOC_NO_CLASS};
            best_w_q <= '{default: '0};
        end else begin
            if (latch_en) begin
                key_q  <= bus.key_c;
                resp_q <= bus.resp_c;
            end
            if (rd_en) begin
                err_q <= !range_ok;
                if (range_ok) begin
                    rd_w_q <= w_mat_q[key_idx][resp_idx];
                end
            end
            // err_q was settled in RD, so an out-of-range request writes nothing.
            if (wr_en && !err_q) begin
                w_mat_q[key_idx][resp_idx] <= w_inc;
                // Strict compare: ties, including a saturated hit, keep the old best.
                if (w_inc > best_w_q[key_idx]) begin
                    best_c_q[key_idx] <= resp_q;
                    best_w_q[key_idx] <= w_inc;
                end
            end
        end
    end

    assign bus.assoc_learning_done = done;
    assign bus.assoc_err           = done & err_q;

    // ---------------- recall datapath ----------------
    // Reads the best tables as registered, so a query coinciding with an UPD
    // write sees the pre-update entry.
    logic               recall_valid_q;
    assoc_class_T       recall_c_q;
    logic [W_WIDTH-1:0] recall_w_q;
    logic               query_ok;
    logic [IDX_W-1:0]   query_idx;

    assign query_ok  = class_in_range(bus.query_c, N_CLASS);
    assign query_idx = bus.query_c[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            recall_valid_q <= 1'b0;
            recall_c_q     <= ASSOC_NO_CLASS;
            recall_w_q     <= '0;
        end else begin
            recall_valid_q <= bus.query_valid;
            if (bus.query_valid) begin
                if (query_ok) begin
                    recall_c_q <= best_c_q[query_idx];
                    recall_w_q <= best_w_q[query_idx];
                end else begin
                    recall_c_q <= ASSOC_NO_CLASS;
                    recall_w_q <= '0;
                end
            end
        end
    end

    assign bus.recall_valid = recall_valid_q;
    assign bus.recall_c     = recall_c_q;
    assign bus.recall_w     = recall_w_q;

endmodule

// File: tb/tb_assoc_layer.sv
// -----------------------------------------------------------------------------
// tb_assoc_layer
// Directed bench for assoc_layer: learn handshake timing, tie/strict-greater
// best tracking, saturation, range errors, busy-start drop, reset mid-update,
// and recall results checked through an expected-result queue.
// -----------------------------------------------------------------------------
module tb_assoc_layer;

    logic clk;
    logic reset;

    assoc_layer_if #(.W_WIDTH(8)) bus ();

    assoc_layer #(.N_CLASS(16), .W_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int c;
        int w;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    // A queued expectation means a query was sampled at this edge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("recall_valid", bus.recall_valid, 1);
            check("recall_c", bus.recall_c, e.c);
            check("recall_w", bus.recall_w, e.w);
        end else begin
            check("recall_idle", bus.recall_valid, 0);
        end
    endtask

    task automatic push_query(input int qc, input int ec, input int ew);
        exp_t e;
        e.c = ec;
        e.w = ew;
        sb.push_back(e);
        bus.query_valid = 1'b1;
        bus.query_c     = qc;
    endtask

    task automatic query(input int qc, input int ec, input int ew);
        push_query(qc, ec, ew);
        tick();
        bus.query_valid = 1'b0;
    endtask

    // One full learn transaction with cycle-exact done/busy checks.
    task automatic learn(input int k, input int r, input logic exp_err);
        bus.assoc_learning_start = 1'b1;
        bus.key_c  = k;
        bus.resp_c = r;
        tick();                                   // edge k -> RD
        bus.assoc_learning_start = 1'b0;
        check("busy_rd", bus.busy, 1);
        check("done_rd", bus.assoc_learning_done, 0);
        tick();                                   // edge k+1 -> UPD
        check("busy_upd", bus.busy, 1);
        check("done_upd", bus.assoc_learning_done, 0);
        tick();                                   // edge k+2 -> DONE
        check("done_pulse", bus.assoc_learning_done, 1);
        check("err", bus.assoc_err, exp_err);
        check("busy_done", bus.busy, 1);
        tick();                                   // edge k+3 -> IDLE
        check("done_end", bus.assoc_learning_done, 0);
        check("busy_idle", bus.busy, 0);
    endtask

    initial begin
        reset                    = 1'b1;
        bus.assoc_learning_start = 1'b0;
        bus.key_c                = 0;
        bus.resp_c               = 0;
        bus.query_valid          = 1'b0;
        bus.query_c              = 0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.assoc_learning_done, 0);
        check("rst_err", bus.assoc_err, 0);
        check("rst_recall_c", bus.recall_c, -1);
        check("rst_recall_w", bus.recall_w, 0);
        query(3, -1, 0);

        // First association
        learn(2, 5, 1'b0);
        query(2, 5, 1);

        // Tie keeps the existing best; strictly greater replaces it
        learn(2, 5, 1'b0);
        query(2, 5, 2);
        learn(2, 7, 1'b0);
        learn(2, 7, 1'b0);
        query(2, 5, 2);
        learn(2, 7, 1'b0);
        query(2, 7, 3);

        // Saturation
        for (int i = 0; i < 255; i++) learn(1, 4, 1'b0);
        query(1, 4, 255);
        for (int i = 0; i < 5; i++) learn(1, 4, 1'b0);
        query(1, 4, 255);

        // Out-of-range classes
        learn(16, 3, 1'b1);
        query(16, -1, 0);
        learn(0, -1, 1'b1);
        query(0, -1, 0);
        learn(-1, 2, 1'b1);
        query(3, -1, 0);

        // Back-to-back queries
        push_query(2, 7, 3);
        tick();
        push_query(1, 4, 255);
        tick();
        push_query(-1, -1, 0);
        tick();
        bus.query_valid = 1'b0;
        tick();

        // Query coinciding with the UPD write sees the pre-update value
        bus.assoc_learning_start = 1'b1;
        bus.key_c  = 3;
        bus.resp_c = 9;
        tick();                                   // RD
        bus.assoc_learning_start = 1'b0;
        tick();                                   // UPD
        push_query(3, -1, 0);
        tick();                                   // write edge
        check("upd_done", bus.assoc_learning_done, 1);
        push_query(3, 9, 1);
        tick();
        bus.query_valid = 1'b0;
        check("upd_done_end", bus.assoc_learning_done, 0);

        // start while busy is dropped
        bus.assoc_learning_start = 1'b1;
        bus.key_c  = 4;
        bus.resp_c = 6;
        tick();                                   // edge k
        bus.resp_c = 9;                           // second start at k+1
        tick();
        bus.assoc_learning_start = 1'b0;
        check("busy_start_done0", bus.assoc_learning_done, 0);
        tick();                                   // edge k+2
        check("busy_start_done1", bus.assoc_learning_done, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("busy_start_no_extra", bus.assoc_learning_done, 0);
        end
        query(4, 6, 1);

        // Reset during UPD discards the pending update
        bus.assoc_learning_start = 1'b1;
        bus.key_c  = 5;
        bus.resp_c = 8;
        tick();                                   // RD
        bus.assoc_learning_start = 1'b0;
        tick();                                   // UPD
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_upd_busy", bus.busy, 0);
        for (int i = 0; i < 4; i++) begin
            check("rst_upd_no_done", bus.assoc_learning_done, 0);
            tick();
        end
        query(5, -1, 0);
        query(2, -1, 0);

        // start and reset together: reset wins
        reset = 1'b1;
        bus.assoc_learning_start = 1'b1;
        bus.key_c  = 0;
        bus.resp_c = 1;
        tick();
        reset = 1'b0;
        bus.assoc_learning_start = 1'b0;
        check("rst_start_busy", bus.busy, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_start_no_done", bus.assoc_learning_done, 0);
        end
        query(0, -1, 0);

        // Learning resumes normally after reset
        learn(0, 1, 1'b0);
        query(0, 1, 1);

        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
